pipeline_hazard_ctrl: RTL

Central stall and flush controller for the 5-stage pipeline. It drives the write enables of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), and the bubble-insert strobes for IF/ID and ID/EX. It resolves load-use hazards, taken branches, instruction-fetch misses and multi-cycle data-memory accesses. A wait-state FSM with a watchdog sits between the MEM stage and the data cache.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/wait_watchdog.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, stage enable bundle
// and the canned enable patterns for each hazard decision.
package hazard_pkg;

  localparam int ZERO_REG_DEF = 31;

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
  } stage_en_t;

  localparam stage_en_t EN_FREEZE = '{default: 1'b0};
  localparam stage_en_t EN_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                      exmem_we: 1'b1, memwb_we: 1'b1,
                                      ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam stage_en_t EN_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                      exmem_we: 1'b1, memwb_we: 1'b1,
                                      ifid_flush: 1'b1, idex_flush: 1'b1};
  // The load in EX advances to MEM while ID holds and a bubble enters EX.
  localparam stage_en_t EN_LOAD_USE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1,
                                        exmem_we: 1'b1, memwb_we: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam stage_en_t EN_FETCH_MISS = '{pc_we: 1'b0, ifid_we: 1'b1, idex_we: 1'b1,
                                          exmem_we: 1'b1, memwb_we: 1'b1,
                                          ifid_flush: 1'b1, idex_flush: 1'b0};

endpackage

// File: rtl/wait_watchdog.sv
// Data-access wait counter with saturation and a sticky hang error that is
// raised once a DWAIT episode reaches MAX_WAIT counted cycles.
module wait_watchdog #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic enter,
  input  logic in_wait,
  input  logic mem_req,
  output logic hang_err
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              at_max;

  assign at_max = (wait_cnt == WAIT_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (enter) begin
      wait_cnt <= '0;
    end else if (in_wait && !at_max) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // A dropped request while waiting is a protocol error, not a hang.
  always_ff @(posedge clk) begin
    if (reset) begin
      hang_err <= 1'b0;
    end else if (in_wait && mem_req && at_max) begin
      hang_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a data-wait FSM.
// Define HAZARD_PERF_EN to build the stall_cycles performance counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             if_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             hang_err,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  stage_en_t   en;
  logic        freeze;
  logic        load_use;
  logic        fetch_miss;

  assign load_use = ex_mem_read && (ex_rd != REG_W'(ZERO_REG)) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign fetch_miss = !if_ready;

  // A held MEM stage re-presents every lower-priority condition after unfreeze.
  assign freeze = ((state == RUN)   && mem_req && !mem_ready) ||
                  ((state == DWAIT) && !mem_ready);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    en        = EN_RUN;

    unique case (state)
      RUN:   if (mem_req && !mem_ready) state_nxt = DWAIT;
      DWAIT: if (mem_ready || !mem_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    if (reset) begin
      en = EN_FREEZE;
    end else if (freeze) begin
      en = EN_FREEZE;
    end else if (ex_branch_taken) begin
      en = EN_BRANCH;
    end else if (load_use) begin
      en = EN_LOAD_USE;
    end else if (fetch_miss) begin
      en = EN_FETCH_MISS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign pc_we      = en.pc_we;
  assign ifid_we    = en.ifid_we;
  assign idex_we    = en.idex_we;
  assign exmem_we   = en.exmem_we;
  assign memwb_we   = en.memwb_we;
  assign ifid_flush = en.ifid_flush;
  assign idex_flush = en.idex_flush;

  wait_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .enter    ((state == RUN) && (state_nxt == DWAIT)),
    .in_wait  (state == DWAIT),
    .mem_req  (mem_req),
    .hang_err (hang_err)
  );

`ifdef HAZARD_PERF_EN
  // Counts every cycle the PC is held: freeze, load-use and fetch miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!en.pc_we && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
